// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit reorder buffer with CDB completion and flush
// Retires at most one done instruction per cycle from head; flush empties the buffer.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int PHY_REG_W = 6,
  parameter int NUM_CDB   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_valid,
  input  logic                     alloc_has_write,
  input  logic [PHY_REG_W-1:0]     alloc_phy_dst,
  input  logic                     alloc_is_branch,
  output logic                     alloc_ready,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_rob_tag,
  input  logic [NUM_CDB-1:0]       cdb_branch_taken,
  input  logic                     flush,
  output logic                     commit_valid,
  output logic                     commit_with_write,
  output logic [PHY_REG_W-1:0]     commited_wr_register,
  output logic                     is_branch_op,
  output logic                     branch_taken,
  output logic [TAG_W:0]           rob_count
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] valid_q, done_q, has_write_q, is_branch_q, taken_q;
  logic [PHY_REG_W-1:0] phy_dst_q [ROB_DEPTH];
  logic [TAG_W:0]       head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [TAG_W-1:0]     head_idx, tail_idx;
  logic                 do_alloc, do_commit;

  assign head_idx    = head_q[TAG_W-1:0];
  assign tail_idx    = tail_q[TAG_W-1:0];
  assign alloc_ready = (count_q != FULL_COUNT);
  assign alloc_tag   = tail_idx;
  assign rob_count   = count_q;
  assign do_alloc    = alloc_valid & alloc_ready;
  assign do_commit   = valid_q[head_idx] & done_q[head_idx];

  // Pointers carry a wrap bit, so plain increment wraps modulo 2*ROB_DEPTH.
  always_comb begin
    head_d  = head_q + {{TAG_W{1'b0}}, do_commit};
    tail_d  = tail_q + {{TAG_W{1'b0}}, do_alloc};
    count_d = count_q;
    if (do_alloc && !do_commit) begin
      count_d = count_q + {{TAG_W{1'b0}}, 1'b1};
    end else if (!do_alloc && do_commit) begin
      count_d = count_q - {{TAG_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      valid_q              <= '0;
      done_q               <= '0;
      head_q               <= '0;
      tail_q               <= '0;
      count_q              <= '0;
      commit_valid         <= 1'b0;
      commit_with_write    <= 1'b0;
      commited_wr_register <= '0;
      is_branch_op         <= 1'b0;
      branch_taken         <= 1'b0;
    end else begin
      // Ascending port order lets the higher-numbered port win on a tag collision.
      for (int p = 0; p < NUM_CDB; p++) begin
        if (cdb_valid[p] && valid_q[cdb_rob_tag[p*TAG_W +: TAG_W]]) begin
          done_q[cdb_rob_tag[p*TAG_W +: TAG_W]]  <= 1'b1;
          taken_q[cdb_rob_tag[p*TAG_W +: TAG_W]] <= cdb_branch_taken[p];
        end
      end

      commit_valid         <= do_commit;
      commit_with_write    <= do_commit & has_write_q[head_idx];
      commited_wr_register <= (do_commit && has_write_q[head_idx]) ? phy_dst_q[head_idx] : '0;
      is_branch_op         <= do_commit & is_branch_q[head_idx];
      branch_taken         <= do_commit & is_branch_q[head_idx] & taken_q[head_idx];

      if (do_commit) begin
        valid_q[head_idx] <= 1'b0;
      end

      if (do_alloc) begin
        valid_q[tail_idx]     <= 1'b1;
        done_q[tail_idx]      <= 1'b0;
        has_write_q[tail_idx] <= alloc_has_write;
        phy_dst_q[tail_idx]   <= alloc_phy_dst;
        is_branch_q[tail_idx] <= alloc_is_branch;
        taken_q[tail_idx]     <= 1'b0;
      end

      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer
// Directed vector table, hand-written corner sequences, then random traffic against a queue model.
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int TW    = 4;
  localparam int PW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          alloc_valid, alloc_has_write, alloc_is_branch;
  logic [PW-1:0] alloc_phy_dst;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic [1:0]    cdb_valid, cdb_branch_taken;
  logic [2*TW-1:0] cdb_rob_tag;
  logic          flush;
  logic          commit_valid, commit_with_write, is_branch_op, branch_taken;
  logic [PW-1:0] commited_wr_register;
  logic [TW:0]   rob_count;

  int n_checks = 0;
  int n_errors = 0;

  reorder_buffer #(.ROB_DEPTH(DEPTH), .PHY_REG_W(PW), .NUM_CDB(2)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_has_write(alloc_has_write),
    .alloc_phy_dst(alloc_phy_dst), .alloc_is_branch(alloc_is_branch),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_branch_taken(cdb_branch_taken),
    .flush(flush),
    .commit_valid(commit_valid), .commit_with_write(commit_with_write),
    .commited_wr_register(commited_wr_register),
    .is_branch_op(is_branch_op), .branch_taken(branch_taken),
    .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic       hw;
    logic [5:0] dst;
    logic [1:0] cv;
    logic [3:0] t0;
    logic       exp_cv;
    logic       exp_wr;
    logic [5:0] exp_dst;
    logic [4:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [3:0] tag;
    logic       hw;
    logic [5:0] dst;
    logic       br;
    logic       done;
    logic       tk;
  } ent_t;

  vec_t vecs[12];
  ent_t q[$];
  int   next_tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_has_write = 0; alloc_phy_dst = '0; alloc_is_branch = 0;
    cdb_valid = '0; cdb_rob_tag = '0; cdb_branch_taken = '0; flush = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic alloc(input logic hw, input logic [5:0] dst, input logic br);
    alloc_valid = 1; alloc_has_write = hw; alloc_phy_dst = dst; alloc_is_branch = br;
  endtask

  task automatic cdb(input logic [1:0] v, input logic [3:0] t0, input logic [3:0] t1, input logic [1:0] tk);
    cdb_valid = v; cdb_rob_tag = {t1, t0}; cdb_branch_taken = tk;
  endtask

  function automatic vec_t mk(input logic av, input logic hw, input logic [5:0] dst,
                              input logic [1:0] cv, input logic [3:0] t0,
                              input logic ecv, input logic ewr, input logic [5:0] edst,
                              input logic [4:0] ecnt);
    vec_t v;
    v.av = av; v.hw = hw; v.dst = dst; v.cv = cv; v.t0 = t0;
    v.exp_cv = ecv; v.exp_wr = ewr; v.exp_dst = edst; v.exp_cnt = ecnt;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Out-of-order completion (dst 5,6,7), then a non-writing instruction.
    vecs[0]  = mk(1, 1, 5, 2'b00, 0, 0, 0, 0, 1);
    vecs[1]  = mk(1, 1, 6, 2'b00, 0, 0, 0, 0, 2);
    vecs[2]  = mk(1, 1, 7, 2'b00, 0, 0, 0, 0, 3);
    vecs[3]  = mk(0, 0, 0, 2'b01, 2, 0, 0, 0, 3);
    vecs[4]  = mk(0, 0, 0, 2'b01, 0, 0, 0, 0, 3);
    vecs[5]  = mk(0, 0, 0, 2'b01, 1, 1, 1, 5, 2);
    vecs[6]  = mk(0, 0, 0, 2'b00, 0, 1, 1, 6, 1);
    vecs[7]  = mk(0, 0, 0, 2'b00, 0, 1, 1, 7, 0);
    vecs[8]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 0, 9, 2'b00, 0, 0, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, 2'b01, 3, 0, 0, 0, 1);
    vecs[11] = mk(0, 0, 0, 2'b00, 0, 1, 0, 0, 0);

    idle();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      alloc_valid = 1'($urandom); alloc_has_write = 1'($urandom);
      alloc_phy_dst = 6'($urandom); alloc_is_branch = 1'($urandom);
      cdb_valid = 2'($urandom); cdb_rob_tag = 8'($urandom); cdb_branch_taken = 2'($urandom);
      flush = 1'($urandom);
      tick();
    end
    chk("reset_commit_valid", commit_valid, 0);
    chk("reset_rob_count", rob_count, 0);
    chk("reset_alloc_ready", alloc_ready, 1);
    chk("reset_wr_register", commited_wr_register, 0);
    chk("reset_is_branch_op", is_branch_op, 0);
    idle();
    reset = 1;

    for (int i = 0; i < 12; i++) begin
      idle();
      if (vecs[i].av) alloc(vecs[i].hw, vecs[i].dst, 0);
      cdb(vecs[i].cv, vecs[i].t0, 0, 2'b00);
      tick();
      chk($sformatf("vec%0d_commit_valid", i), commit_valid, vecs[i].exp_cv);
      chk($sformatf("vec%0d_with_write", i), commit_with_write, vecs[i].exp_wr);
      chk($sformatf("vec%0d_wr_register", i), commited_wr_register, vecs[i].exp_dst);
      chk($sformatf("vec%0d_rob_count", i), rob_count, vecs[i].exp_cnt);
    end

    // Full and wrap.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(1, 6'(i), 0);
      chk("full_alloc_tag", alloc_tag, i);
      tick();
    end
    idle();
    chk("full_rob_count", rob_count, 16);
    chk("full_alloc_ready", alloc_ready, 0);
    alloc(1, 63, 0);
    tick();
    idle();
    chk("full_17th_ignored_count", rob_count, 16);
    chk("full_17th_commit_valid", commit_valid, 0);
    cdb(2'b01, 0, 0, 2'b00);
    tick();
    idle();
    chk("full_cdb_count", rob_count, 16);
    tick();
    chk("wrap_commit_valid", commit_valid, 1);
    chk("wrap_commit_dst", commited_wr_register, 0);
    chk("wrap_commit_with_write", commit_with_write, 1);
    chk("wrap_rob_count", rob_count, 15);
    chk("wrap_alloc_ready", alloc_ready, 1);
    chk("wrap_alloc_tag", alloc_tag, 0);
    alloc(1, 40, 0);
    tick();
    idle();
    chk("wrap_refill_count", rob_count, 16);

    // Branch commit then flush.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc(1, 6'(10 + i), i == 3);
      tick();
    end
    idle();
    cdb(2'b11, 0, 1, 2'b00);
    tick();
    idle();
    cdb(2'b11, 2, 3, 2'b10);
    tick();
    idle();
    chk("br_commit0_dst", commited_wr_register, 10);
    alloc(1, 50, 0);
    tick();
    idle();
    chk("br_commit1_dst", commited_wr_register, 11);
    alloc(1, 51, 0);
    tick();
    idle();
    chk("br_commit2_dst", commited_wr_register, 12);
    chk("br_commit2_not_branch", is_branch_op, 0);
    tick();
    chk("br_commit3_valid", commit_valid, 1);
    chk("br_commit3_dst", commited_wr_register, 13);
    chk("br_commit3_is_branch", is_branch_op, 1);
    chk("br_commit3_taken", branch_taken, 1);
    chk("br_pre_flush_count", rob_count, 2);
    flush = 1;
    tick();
    idle();
    chk("flush_rob_count", rob_count, 0);
    chk("flush_commit_valid", commit_valid, 0);
    chk("flush_alloc_tag", alloc_tag, 0);
    cdb(2'b11, 2, 4, 2'b00);
    tick();
    idle();
    tick();
    chk("flush_stale_cdb_no_commit", commit_valid, 0);
    chk("flush_stale_cdb_count", rob_count, 0);
    alloc(1, 55, 0);
    chk("flush_new_alloc_tag", alloc_tag, 0);
    tick();
    idle();
    cdb(2'b01, 0, 0, 2'b00);
    tick();
    idle();
    tick();
    chk("flush_new_commit_valid", commit_valid, 1);
    chk("flush_new_commit_dst", commited_wr_register, 55);

    // Same-cycle alloc + commit + duplicate-tag CDB at count 8.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc(1, 6'(20 + i), i == 5);
      tick();
    end
    idle();
    cdb(2'b01, 0, 0, 2'b00);
    tick();
    idle();
    chk("same_pre_count", rob_count, 8);
    alloc(1, 30, 0);
    cdb(2'b11, 5, 5, 2'b10);
    tick();
    idle();
    chk("same_rob_count", rob_count, 8);
    chk("same_commit_valid", commit_valid, 1);
    chk("same_commit_dst", commited_wr_register, 20);
    chk("same_no_x", 32'($isunknown({commit_valid, commit_with_write, commited_wr_register,
                                      is_branch_op, branch_taken, rob_count, alloc_ready})), 0);
    cdb(2'b11, 1, 2, 2'b00);
    tick();
    idle();
    chk("same_single_commit", commit_valid, 0);
    chk("same_hold_count", rob_count, 8);
    cdb(2'b11, 3, 4, 2'b00);
    for (int k = 0; k < 5; k++) begin
      tick();
      idle();
      chk($sformatf("same_drain%0d_valid", k), commit_valid, 1);
      chk($sformatf("same_drain%0d_dst", k), commited_wr_register, 21 + k);
      chk($sformatf("same_drain%0d_branch", k), is_branch_op, k == 4);
      chk($sformatf("same_drain%0d_taken", k), branch_taken, k == 4);
      chk($sformatf("same_drain%0d_count", k), rob_count, 7 - k);
    end

    // Mid-operation reset, then random traffic against the queue model.
    do_reset();
    chk("midreset_rob_count", rob_count, 0);
    chk("midreset_commit_valid", commit_valid, 0);
    q.delete();
    next_tag = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int         pct;
      logic [1:0] v, tk;
      logic [3:0] t [2];
      logic       e_cv, e_wr, e_br, e_tk, accept;
      logic [5:0] e_dst;
      ent_t       ne;

      pct = ((cyc / 250) % 2 == 0) ? 80 : 35;
      alloc_valid     = ($urandom_range(99) < pct);
      alloc_has_write = 1'($urandom);
      alloc_phy_dst   = 6'($urandom);
      alloc_is_branch = ($urandom_range(3) == 0);
      for (int p = 0; p < 2; p++) begin
        v[p]  = ($urandom_range(2) != 0);
        tk[p] = 1'($urandom);
        if (q.size() > 0 && $urandom_range(3) != 0) t[p] = q[$urandom_range(q.size() - 1)].tag;
        else t[p] = 4'($urandom_range(15));
      end
      cdb(v, t[0], t[1], tk);
      flush = ($urandom_range(79) == 0);

      chk("rand_alloc_ready", alloc_ready, q.size() < DEPTH);
      chk("rand_alloc_tag", alloc_tag, next_tag % DEPTH);

      e_cv  = !flush && q.size() > 0 && q[0].done;
      e_wr  = e_cv && q[0].hw;
      e_dst = e_wr ? q[0].dst : 6'd0;
      e_br  = e_cv && q[0].br;
      e_tk  = e_br && q[0].tk;

      if (flush) begin
        q.delete();
        next_tag = 0;
      end else begin
        accept = alloc_valid && q.size() < DEPTH;
        for (int p = 0; p < 2; p++) begin
          if (v[p]) begin
            foreach (q[i]) if (q[i].tag == t[p]) begin
              q[i].done = 1;
              q[i].tk   = tk[p];
            end
          end
        end
        if (e_cv) void'(q.pop_front());
        if (accept) begin
          ne.tag = 4'(next_tag % DEPTH); ne.hw = alloc_has_write; ne.dst = alloc_phy_dst;
          ne.br = alloc_is_branch; ne.done = 0; ne.tk = 0;
          q.push_back(ne);
          next_tag++;
        end
      end

      tick();
      chk("rand_commit_valid", commit_valid, e_cv);
      chk("rand_commit_with_write", commit_with_write, e_wr);
      chk("rand_wr_register", commited_wr_register, e_dst);
      chk("rand_is_branch_op", is_branch_op, e_br);
      chk("rand_branch_taken", branch_taken, e_tk);
      chk("rand_rob_count", rob_count, q.size());
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
